serial_adder: RTL
=================

# serial_adder

Bit-serial N-bit adder built around a single full-adder cell and a registered carry. It accepts two parallel operands plus carry-in on a start strobe and processes one bit per clock, LSB first. It returns the parallel sum and carry-out with a one-cycle done pulse. It sits downstream of the combinational full adder and replaces a WIDTH-wide ripple adder where area matters more than latency.

## Interface

- WIDTH, default 8, operand/sum width in bits; legal range ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in; captured with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result; registered, held between operations.
- cout  output  1  final carry; registered, held.
- sub  input  1  only when SERIAL_ADDER_SUB_EN is defined; subtract request, captured with start.

## Operation

- Reset (rst_n=0 at a clk edge): state IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry and counter cleared. Reset has priority over everything, including mid-RUN: the operation is aborted and no done is produced.
- FSM states:
  - IDLE → RUN when start=1. Load shift regs a_sh=a, b_sh=b. Load carry=cin. Clear counter.
  - RUN: each edge computes s = a_sh[0]^b_sh[0]^carry and carry ← majority(a_sh[0], b_sh[0], carry). s shifts into the MSB of the internal sum_sh, and a_sh/b_sh shift right. The counter increments. On the edge where counter == WIDTH-1: sum ← final sum_sh value, cout ← final carry, state → DONE.
  - DONE → IDLE unconditionally after one cycle.
- start is ignored in RUN and DONE; operands changing while busy have no effect.
- sum/cout change only on the final RUN edge (or reset); they are stable in all other cycles.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- WIDTH=1: RUN lasts one edge. Counter width is max(1, $clog2(WIDTH)).

## Timing

- Accepting edge E0 (IDLE, start=1) → busy=1 from E0.
- Bits processed on edges E1..E_WIDTH. done=1 and the new sum/cout are valid in the cycle after edge E_WIDTH.
- busy=0 again after edge E_WIDTH+1 (IDLE). The earliest next accept is edge E_WIDTH+2.
- With start held high continuously: one operation per WIDTH+2 cycles.
- done is never asserted for more than one cycle and never in the cycle following reset.

## Configuration

- SERIAL_ADDER_SUB_EN defined: the sub port exists.
  - sub=1 at accept: b is captured inverted (b_sh=~b) and carry=1, with cin ignored. Result is sum = a - b mod 2^WIDTH, with cout=1 meaning no borrow (a ≥ b).
  - sub=0: identical to add mode.
- Not defined: no sub port; the block is add-only with logic as described above.

## Test plan

- Reset: rst_n=0 for 2 edges with random a/b/start → busy=0, done=0, sum=0, cout=0. After release with start=0, all outputs stay 0.
- Add, WIDTH=8: a=8'h5A, b=8'h33, cin=0, start pulse → done exactly 8 cycles after accept edge, sum=8'h8D, cout=0. busy high 9 cycles.
- Carry chain: a=8'hFF, b=8'h01, cin=1 → sum=8'h01, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Back-to-back and ignore: start held high; a/b changed to 8'h00/8'h00 during RUN → first result still uses captured operands. Second accept occurs exactly 10 edges after the first. sum holds the first result until the second done.
- Reset mid-operation: rst_n=0 after 3 RUN edges → next cycle busy=0, done=0, sum=0, cout=0, and no done follows. A fresh start with a=8'h10, b=8'h20 then yields sum=8'h30.
- SERIAL_ADDER_SUB_EN: sub=1, a=8'h10, b=8'h03 → sum=8'h0D, cout=1. Then a=8'h03, b=8'h10 → sum=8'hF3, cout=0.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one full-adder cell, LSB first
// Optional subtract mode: define SERIAL_ADDER_SUB_EN to add the sub port.

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_next;
  logic [CW-1:0]    count;
  logic             carry;
  logic             carry_next;
  logic             bit_sum;
  logic             last;
  logic             b_inv;
  logic             carry_load;

  // Subtraction is a + ~b + 1; cin is ignored when sub is requested.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_inv      = sub;
  assign carry_load = sub | cin;
`else
  assign b_inv      = 1'b0;
  assign carry_load = cin;
`endif

  assign last       = (state == RUN) && (count == LAST_BIT);
  assign bit_sum    = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  always_comb begin
    sum_sh_next            = sum_sh >> 1;
    sum_sh_next[WIDTH-1]   = bit_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b ^ {WIDTH{b_inv}};
            carry  <= carry_load;
            sum_sh <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_sh_next;
          carry  <= carry_next;
          count  <= count + 1'b1;
          // Results are published only on the final bit so sum/cout stay stable otherwise.
          if (last) begin
            sum  <= sum_sh_next;
            cout <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
